// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by the encoder, decoder and channel stages.
// Codeword bit positions are fixed here, so every stage agrees on the wire order.
package hamming_pkg;
  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  typedef enum logic {HUNT, SHIFT} state_t;

  localparam int D3 = 6;
  localparam int D2 = 5;
  localparam int D1 = 4;
  localparam int P4 = 3;
  localparam int D0 = 2;
  localparam int P2 = 1;
  localparam int P1 = 0;
endpackage

// File: rtl/hamming_cw_deserializer_if.sv
// Channel-side serial input, codeword handshake and statistics of the deserializer.
// The slave modport is the deserializer's view of these signals; master is the driver's view.
interface hamming_cw_deserializer_if #(parameter int CNT_W = 16);
  import hamming_pkg::*;

  logic             sync_i;
  logic             bit_i;
  logic             bit_valid_i;
  logic             clr_i;
  logic [CW_W-1:0]  cw_o;
  logic             cw_valid_o;
  logic             cw_ready_i;
  logic             overflow_o;
  logic [CNT_W-1:0] frame_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic [CNT_W-1:0] abort_cnt_o;

  modport slave (
    input  sync_i, bit_i, bit_valid_i, clr_i, cw_ready_i,
    output cw_o, cw_valid_o, overflow_o, frame_cnt_o, drop_cnt_o, abort_cnt_o
  );

  modport master (
    output sync_i, bit_i, bit_valid_i, clr_i, cw_ready_i,
    input  cw_o, cw_valid_o, overflow_o, frame_cnt_o, drop_cnt_o, abort_cnt_o
  );
endinterface

// File: rtl/hamming_cw_deserializer_sat_counter.sv
// Event counter that saturates at all-ones; a synchronous clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hamming_cw_deserializer.sv
// Assembles a sync-framed bit-serial stream into 7-bit codewords behind a one-entry valid/ready register.
// Latency is 1 clk from the 7th bit to cw_valid_o; a word completing while the register is stalled is dropped.
module hamming_cw_deserializer
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  hamming_cw_deserializer_if.slave io
);
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [CW_W-2:0] shift;
  logic [CW_W-1:0] cw;
  logic            cw_valid;
  logic            overflow;

  logic            start;
  logic            complete;
  logic            abort;
  logic            xfer;
  logic            drop;
  logic            load;

  // The first bit of a word is the MSB, so a left shift leaves it at bit 6 after seven bits.
  assign start    = io.bit_valid_i && io.sync_i;
  assign complete = io.bit_valid_i && !io.sync_i && (state == SHIFT) && (bit_cnt == 3'd6);
  assign abort    = start && (state == SHIFT) && (bit_cnt != 3'd0);
  assign xfer     = cw_valid && io.cw_ready_i;
  assign drop     = complete && cw_valid && !io.cw_ready_i;
  assign load     = complete && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      bit_cnt  <= 3'd0;
      shift    <= '0;
      cw       <= '0;
      cw_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start) begin
        state   <= SHIFT;
        bit_cnt <= 3'd1;
        shift   <= {{(CW_W-2){1'b0}}, io.bit_i};
      end else if (io.bit_valid_i && (state == SHIFT)) begin
        if (bit_cnt == 3'd6) begin
          state   <= HUNT;
          bit_cnt <= 3'd0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
        shift <= {shift[CW_W-3:0], io.bit_i};
      end

      if (load) begin
        cw       <= {shift, io.bit_i};
        cw_valid <= 1'b1;
      end else if (xfer) begin
        cw_valid <= 1'b0;
      end

      if (io.clr_i) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign io.cw_o       = cw;
  assign io.cw_valid_o = cw_valid;
  assign io.overflow_o = overflow;

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk(clk), .rst(rst), .inc(xfer),  .clr(io.clr_i), .cnt(io.frame_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .rst(rst), .inc(drop),  .clr(io.clr_i), .cnt(io.drop_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_abort_cnt (
    .clk(clk), .rst(rst), .inc(abort), .clr(io.clr_i), .cnt(io.abort_cnt_o)
  );
endmodule

// File: tb/tb_hamming_cw_deserializer.sv
// Directed bench for the codeword deserializer: framing, early sync, backpressure, reset and clear.
module tb_hamming_cw_deserializer;
  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic       sat_inc = 1'b0;
  logic       sat_clr = 1'b0;
  logic [1:0] sat_cnt;

  hamming_cw_deserializer_if #(.CNT_W(16)) bus ();

  hamming_cw_deserializer #(.CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  sat_counter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .inc(sat_inc), .clr(sat_clr), .cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic s, input logic b);
    @(negedge clk);
    bus.sync_i      = s;
    bus.bit_i       = b;
    bus.bit_valid_i = 1'b1;
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 0; i < 7; i++) send_bit(i == 0, w[6-i]);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sync_i      = 1'b0;
    bus.bit_i       = 1'b0;
    bus.bit_valid_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
  endtask

  initial begin
    logic [6:0] w;
    rst             = 1'b1;
    bus.sync_i      = 1'b0;
    bus.bit_i       = 1'b0;
    bus.bit_valid_i = 1'b0;
    bus.clr_i       = 1'b0;
    bus.cw_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cw",       16'(bus.cw_o),   16'h0);
    check("reset_valid",    16'(bus.cw_valid_o), 16'h0);
    check("reset_overflow", 16'(bus.overflow_o), 16'h0);
    check("reset_frame",    bus.frame_cnt_o, 16'h0);
    check("reset_drop",     bus.drop_cnt_o,  16'h0);
    check("reset_abort",    bus.abort_cnt_o, 16'h0);
    rst = 1'b0;

    // Single word
    send_word(7'b1011010);
    idle();
    check("single_valid", 16'(bus.cw_valid_o), 16'h1);
    check("single_cw",    16'(bus.cw_o), 16'h5A);
    check("single_frame_pre", bus.frame_cnt_o, 16'h0);
    idle();
    check("single_frame", bus.frame_cnt_o, 16'h1);
    check("single_cleared", 16'(bus.cw_valid_o), 16'h0);

    // Stray bits in HUNT, then a gapped word with sync high on invalid cycles
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    idle();
    check("stray_ignored", 16'(bus.cw_valid_o), 16'h0);
    w = 7'b1011010;
    for (int i = 0; i < 7; i++) begin
      send_bit(i == 0, w[6-i]);
      @(negedge clk);
      bus.bit_valid_i = 1'b0;
      bus.sync_i      = 1'b1;
    end
    check("gap_valid", 16'(bus.cw_valid_o), 16'h1);
    check("gap_cw",    16'(bus.cw_o), 16'h5A);
    check("gap_no_abort", bus.abort_cnt_o, 16'h0);
    idle();
    check("gap_frame", bus.frame_cnt_o, 16'h2);

    // Early sync
    pulse_clr();
    check("clr_frame", bus.frame_cnt_o, 16'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(7'b1111111);
    idle();
    check("early_valid", 16'(bus.cw_valid_o), 16'h1);
    check("early_cw",    16'(bus.cw_o), 16'h7F);
    check("early_abort", bus.abort_cnt_o, 16'h1);
    idle();
    check("early_frame", bus.frame_cnt_o, 16'h1);

    // Backpressure: second back-to-back word is dropped
    bus.cw_ready_i = 1'b0;
    pulse_clr();
    send_word(7'b0000111);
    send_word(7'b1110000);
    idle();
    check("bp_cw",       16'(bus.cw_o), 16'h07);
    check("bp_valid",    16'(bus.cw_valid_o), 16'h1);
    check("bp_drop",     bus.drop_cnt_o, 16'h1);
    check("bp_overflow", 16'(bus.overflow_o), 16'h1);
    check("bp_frame_hold", bus.frame_cnt_o, 16'h0);
    @(negedge clk);
    bus.cw_ready_i = 1'b1;
    @(negedge clk);
    check("bp_xfer_valid", 16'(bus.cw_valid_o), 16'h0);
    check("bp_xfer_frame", bus.frame_cnt_o, 16'h1);

    // Transfer and completion on the same edge
    bus.cw_ready_i = 1'b0;
    pulse_clr();
    check("clr_overflow", 16'(bus.overflow_o), 16'h0);
    send_word(7'b0101010);
    w = 7'b1100110;
    for (int i = 0; i < 6; i++) send_bit(i == 0, w[6-i]);
    @(negedge clk);
    bus.cw_ready_i  = 1'b1;
    bus.sync_i      = 1'b0;
    bus.bit_i       = w[0];
    bus.bit_valid_i = 1'b1;
    idle();
    check("sim_valid", 16'(bus.cw_valid_o), 16'h1);
    check("sim_cw",    16'(bus.cw_o), 16'h66);
    check("sim_drop",  bus.drop_cnt_o, 16'h0);
    check("sim_frame", bus.frame_cnt_o, 16'h1);
    idle();
    check("sim_frame2", bus.frame_cnt_o, 16'h2);

    // Reset mid-word with a held word and nonzero statistics
    bus.cw_ready_i = 1'b0;
    pulse_clr();
    send_word(7'b0110011);
    send_word(7'b1000000);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    idle();
    check("pre_rst_valid", 16'(bus.cw_valid_o), 16'h1);
    check("pre_rst_drop",  bus.drop_cnt_o, 16'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_cw",       16'(bus.cw_o), 16'h0);
    check("arst_valid",    16'(bus.cw_valid_o), 16'h0);
    check("arst_overflow", 16'(bus.overflow_o), 16'h0);
    check("arst_drop",     bus.drop_cnt_o, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Clear while a drop happens in the same cycle
    send_word(7'b0110011);
    send_word(7'b1000000);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_word(7'b1111000);
    w = 7'b1010101;
    for (int i = 0; i < 6; i++) send_bit(i == 0, w[6-i]);
    @(negedge clk);
    check("pre_clr_drop",     bus.drop_cnt_o, 16'h2);
    check("pre_clr_abort",    bus.abort_cnt_o, 16'h1);
    check("pre_clr_overflow", 16'(bus.overflow_o), 16'h1);
    bus.clr_i       = 1'b1;
    bus.sync_i      = 1'b0;
    bus.bit_i       = w[0];
    bus.bit_valid_i = 1'b1;
    idle();
    bus.clr_i = 1'b0;
    check("clr_drop",     bus.drop_cnt_o, 16'h0);
    check("clr_abort",    bus.abort_cnt_o, 16'h0);
    check("clr_overflow2", 16'(bus.overflow_o), 16'h0);
    check("clr_keep_valid", 16'(bus.cw_valid_o), 16'h1);
    check("clr_keep_cw",  16'(bus.cw_o), 16'h33);

    // Saturation of a narrow counter
    @(negedge clk);
    sat_inc = 1'b1;
    repeat (2) @(negedge clk);
    check("sat_two", 16'(sat_cnt), 16'h2);
    repeat (3) @(negedge clk);
    check("sat_hold", 16'(sat_cnt), 16'h3);
    sat_clr = 1'b1;
    @(negedge clk);
    check("sat_clr", 16'(sat_cnt), 16'h0);
    sat_clr = 1'b0;
    sat_inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
